// File: rtl/prim_arb_rsp_route_pkg.sv
// prim_arb_rsp_route_pkg: index and occupancy-counter width helpers for the response router and its index FIFO
package prim_arb_rsp_route_pkg;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/prim_arb_rsp_idx_fifo.sv
// prim_arb_rsp_idx_fifo: in-order index FIFO (push_i/wdata_i write, pop_i advance, head_o/full_o/empty_o/count_o status)
module prim_arb_rsp_idx_fifo
   import prim_arb_rsp_route_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned IdxW = 3,
   localparam int unsigned CntW = cnt_width(Depth)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic [IdxW-1:0] wdata_i,
   input  logic            pop_i,
   output logic [IdxW-1:0] head_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);
   localparam int unsigned PtrW = ptr_width(Depth);
   localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);
   logic [IdxW-1:0] mem [Depth];
   logic [PtrW-1:0] wptr, rptr;
   logic [CntW-1:0] count;
   assign full_o = count == CntW'(Depth);
   assign empty_o = count == '0;
   assign count_o = count;
   assign head_o = mem[rptr];
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wptr] <= wdata_i;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         if (push_i) wptr <= (wptr == Last) ? '0 : wptr + 1'b1;
         if (pop_i) rptr <= (rptr == Last) ? '0 : rptr + 1'b1;
         count <= count + CntW'(push_i) - CntW'(pop_i);
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push_i && full_o)) else $error("push while full");
         assert (!(pop_i && empty_o)) else $error("pop while empty");
         assert (count <= CntW'(Depth)) else $error("count above depth");
      end
   end
endmodule

// File: rtl/prim_arb_rsp_route.sv
// prim_arb_rsp_route: forwards arbiter winner (arb_*) to sink (req_*), queues winner idx, routes sink rsp_* back one-hot per requester
module prim_arb_rsp_route
   import prim_arb_rsp_route_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 32,
   parameter int unsigned Depth = 4,
   localparam int unsigned IdxW = idx_width(N),
   localparam int unsigned CntW = cnt_width(Depth)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            arb_valid_i,
   input  logic [DW-1:0]   arb_data_i,
   input  logic [IdxW-1:0] arb_idx_i,
   output logic            arb_ready_o,
   output logic            req_valid_o,
   output logic [DW-1:0]   req_data_o,
   input  logic            req_ready_i,
   input  logic            rsp_valid_i,
   input  logic [RW-1:0]   rsp_data_i,
   output logic            rsp_ready_o,
   output logic [N-1:0]    rsp_valid_o,
   output logic [RW-1:0]   rsp_data_o,
   input  logic [N-1:0]    rsp_ready_i,
   output logic [CntW-1:0] outstanding_o
);
   logic full, empty, push, pop;
   logic [IdxW-1:0] head;
   assign req_valid_o = arb_valid_i & ~full & ~rst_i;
   assign arb_ready_o = req_ready_i & ~full & ~rst_i;
   assign req_data_o = arb_data_i;
   assign push = req_valid_o & req_ready_i;
   assign rsp_ready_o = ~empty & ~rst_i & rsp_ready_i[head];
   assign rsp_data_o = rsp_data_i;
   assign pop = rsp_valid_i & rsp_ready_o;
   for (genvar i = 0; i < N; i++) begin : g_demux
      assign rsp_valid_o[i] = rsp_valid_i & ~empty & ~rst_i & (head == IdxW'(i));
   end
   prim_arb_rsp_idx_fifo #(.Depth(Depth), .IdxW(IdxW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i (arb_idx_i),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (outstanding_o)
   );
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(rsp_valid_o)) else $error("rsp_valid_o not onehot0");
         assert (!(rsp_valid_i && empty)) else $warning("response with no outstanding request");
      end
   end
endmodule

// File: tb/tb_prim_arb_rsp_route.sv
// tb_prim_arb_rsp_route: directed bench comparing Depth=4 and Depth=3 routers against a queue model every cycle
module tb_prim_arb_rsp_route;
   localparam int N = 4;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic arb_valid = 0, req_ready = 0, rsp_valid = 0;
   logic [7:0] arb_data = 0, rsp_data = 0;
   logic [1:0] arb_idx = 0;
   logic [3:0] rsp_ready = 0;
   logic arb_ready_a [2], req_valid_a [2], rsp_ready_a [2];
   logic [7:0] req_data_a [2], rsp_data_a [2];
   logic [3:0] rsp_valid_a [2];
   logic [2:0] out_a [2];
   int checks = 0, errors = 0;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : 3;
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0] o;
      prim_arb_rsp_route #(.N(N), .DW(8), .RW(8), .Depth(D)) u_dut (
         .clk_i(clk), .rst_i(rst),
         .arb_valid_i(arb_valid), .arb_data_i(arb_data), .arb_idx_i(arb_idx), .arb_ready_o(arb_ready_a[g]),
         .req_valid_o(req_valid_a[g]), .req_data_o(req_data_a[g]), .req_ready_i(req_ready),
         .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_ready_o(rsp_ready_a[g]),
         .rsp_valid_o(rsp_valid_a[g]), .rsp_data_o(rsp_data_a[g]), .rsp_ready_i(rsp_ready),
         .outstanding_o(o)
      );
      assign out_a[g] = 3'(o);
   end
   task automatic chk(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[inst%0d]: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
      end
   endtask
   int q [2][$];
   int depth [2] = '{4, 3};
   bit m_push, m_pop;
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) q[k].delete();
         else begin
            m_push = arb_valid && req_ready && q[k].size() < depth[k];
            m_pop = rsp_valid && q[k].size() > 0 && rsp_ready[q[k][0]];
            if (m_pop) void'(q[k].pop_front());
            if (m_push) q[k].push_back(int'(arb_idx));
         end
      end
   end
   int sz, hd;
   bit nfull;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         sz = q[k].size();
         hd = (sz > 0) ? q[k][0] : 0;
         nfull = sz < depth[k];
         chk("arb_ready", k, int'(arb_ready_a[k]), int'(!rst && req_ready && nfull));
         chk("req_valid", k, int'(req_valid_a[k]), int'(!rst && arb_valid && nfull));
         chk("req_data", k, int'(req_data_a[k]), int'(arb_data));
         chk("rsp_data", k, int'(rsp_data_a[k]), int'(rsp_data));
         chk("rsp_valid", k, int'(rsp_valid_a[k]), (!rst && rsp_valid && sz > 0) ? (1 << hd) : 0);
         chk("rsp_ready", k, int'(rsp_ready_a[k]), int'(!rst && sz > 0 && rsp_ready[hd]));
         chk("outstanding", k, int'(out_a[k]), sz);
      end
   end
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic smp();
      @(negedge clk);
   endtask
   initial begin
      arb_valid = 1; req_ready = 1; rsp_valid = 1; rsp_ready = 4'hF;
      smp();
      chk("rst_arb_ready", 0, int'(arb_ready_a[0]), 0);
      chk("rst_req_valid", 0, int'(req_valid_a[0]), 0);
      chk("rst_rsp_valid", 0, int'(rsp_valid_a[0]), 0);
      chk("rst_rsp_ready", 0, int'(rsp_ready_a[0]), 0);
      nxt(); rst = 0; arb_valid = 0; rsp_valid = 0;
      smp(); chk("rst_outstanding", 0, int'(out_a[0]), 0);
      nxt(); arb_valid = 1; arb_idx = 2; arb_data = 8'hA5;
      smp();
      chk("single_req_valid", 0, int'(req_valid_a[0]), 1);
      chk("single_req_data", 0, int'(req_data_a[0]), 8'hA5);
      nxt(); arb_valid = 0; rsp_valid = 1; rsp_data = 8'h5A;
      smp();
      chk("single_outstanding", 0, int'(out_a[0]), 1);
      chk("single_rsp_valid", 0, int'(rsp_valid_a[0]), 4'b0100);
      chk("single_rsp_data", 0, int'(rsp_data_a[0]), 8'h5A);
      nxt(); rsp_valid = 0;
      smp(); chk("single_drained", 0, int'(out_a[0]), 0);
      for (int i = 0; i < 4; i++) begin
         nxt(); arb_valid = 1; arb_idx = 2'(i); arb_data = 8'(8'h10 + i);
      end
      nxt(); arb_idx = 0;
      smp();
      chk("full_outstanding", 0, int'(out_a[0]), 4);
      chk("full_arb_ready", 0, int'(arb_ready_a[0]), 0);
      chk("full_req_valid", 0, int'(req_valid_a[0]), 0);
      nxt(); rsp_valid = 1;
      smp();
      chk("full_pop_arb_ready", 0, int'(arb_ready_a[0]), 0);
      chk("full_pop_rsp_valid", 0, int'(rsp_valid_a[0]), 4'b0001);
      nxt(); rsp_valid = 0; arb_valid = 0;
      smp();
      chk("after_pop_outstanding", 0, int'(out_a[0]), 3);
      chk("after_pop_arb_ready", 0, int'(arb_ready_a[0]), 1);
      rsp_valid = 1;
      repeat (3) nxt();
      rsp_valid = 0;
      smp(); chk("drain_outstanding", 0, int'(out_a[0]), 0);
      nxt(); arb_valid = 1; arb_idx = 3;
      nxt(); arb_idx = 1;
      nxt(); arb_valid = 0; rsp_valid = 1; rsp_ready = 4'b0001;
      smp();
      chk("stall_rsp_valid", 0, int'(rsp_valid_a[0]), 4'b1000);
      chk("stall_rsp_ready", 0, int'(rsp_ready_a[0]), 0);
      nxt();
      smp(); chk("stall_held", 0, int'(out_a[0]), 2);
      nxt(); rsp_ready = 4'b1000;
      smp(); chk("unstall_rsp_ready", 0, int'(rsp_ready_a[0]), 1);
      nxt(); rsp_ready = 4'b0010;
      smp();
      chk("next_head_rsp_valid", 0, int'(rsp_valid_a[0]), 4'b0010);
      chk("next_head_outstanding", 0, int'(out_a[0]), 1);
      nxt(); rsp_valid = 0; rsp_ready = 4'hF;
      smp(); chk("stall_drained", 0, int'(out_a[0]), 0);
      nxt(); arb_valid = 1; arb_idx = 0;
      nxt(); arb_idx = 1;
      nxt(); arb_idx = 2; rsp_valid = 1;
      smp(); chk("pushpop_before", 0, int'(out_a[0]), 2);
      nxt(); arb_valid = 0; rsp_valid = 0;
      smp(); chk("pushpop_after", 0, int'(out_a[0]), 2);
      rsp_valid = 1;
      repeat (2) nxt();
      rsp_valid = 0;
      smp(); chk("pushpop_drained", 0, int'(out_a[0]), 0);
      for (int i = 0; i < 10; i++) begin
         nxt(); arb_valid = 1; arb_idx = 2'(i % 4); arb_data = 8'(i); rsp_valid = 1; rsp_data = 8'(8'h80 + i);
         smp();
         if (i > 0) begin
            chk("wrap_rsp_valid", 0, int'(rsp_valid_a[0]), 1 << ((i - 1) % 4));
            chk("wrap_rsp_valid", 1, int'(rsp_valid_a[1]), 1 << ((i - 1) % 4));
         end
      end
      nxt(); arb_valid = 0;
      nxt(); rsp_valid = 0;
      smp();
      chk("wrap_drained", 0, int'(out_a[0]), 0);
      chk("wrap_drained", 1, int'(out_a[1]), 0);
      nxt(); rsp_valid = 1;
      smp();
      chk("unexp_rsp_ready", 0, int'(rsp_ready_a[0]), 0);
      chk("unexp_rsp_valid", 0, int'(rsp_valid_a[0]), 0);
      nxt(); rsp_valid = 0; arb_valid = 1; arb_idx = 1;
      nxt(); arb_idx = 2;
      nxt(); arb_idx = 3;
      nxt(); arb_valid = 0;
      smp(); chk("pre_rst_outstanding", 0, int'(out_a[0]), 3);
      nxt(); rst = 1; arb_valid = 1; rsp_valid = 1; rsp_ready = 4'hF;
      smp();
      chk("midrst_arb_ready", 0, int'(arb_ready_a[0]), 0);
      chk("midrst_req_valid", 0, int'(req_valid_a[0]), 0);
      chk("midrst_rsp_valid", 0, int'(rsp_valid_a[0]), 0);
      chk("midrst_rsp_ready", 0, int'(rsp_ready_a[0]), 0);
      nxt(); rst = 0; arb_valid = 0;
      smp();
      chk("post_rst_outstanding", 0, int'(out_a[0]), 0);
      chk("post_rst_rsp_valid", 0, int'(rsp_valid_a[0]), 0);
      chk("post_rst_rsp_ready", 0, int'(rsp_ready_a[0]), 0);
      nxt(); rsp_valid = 0;
      smp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prim_arb_rsp_route.md
# prim_arb_rsp_route

Downstream companion of the N:1 round-robin arbiter. It forwards the arbiter's winning request to a single sink and records the winner index in an in-order outstanding-transaction queue. It then routes each sink response back to the requester that issued it. It also provides back-pressure: the arbiter sees ready only when the sink is ready and the queue has space.

## Interface
Parameters:
- N, 8, number of requesters; N >= 1
- DW, 32, request data width
- RW, 32, response data width
- Depth, 4, maximum outstanding transactions; Depth >= 1
- IdxW (derived), max(1, $clog2(N))
- CntW (derived), $clog2(Depth+1)

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- arb_valid_i  in  1  arbiter valid_o
- arb_data_i  in  DW  arbiter data_o
- arb_idx_i  in  IdxW  arbiter idx_o
- arb_ready_o  out  1  drives arbiter ready_i
- req_valid_o  out  1  request valid to sink
- req_data_o  out  DW  request data to sink, equal to arb_data_i
- req_ready_i  in  1  sink accepts request
- rsp_valid_i  in  1  response valid from sink
- rsp_data_i  in  RW  response data from sink
- rsp_ready_o  out  1  response consumed
- rsp_valid_o  out  N  per-requester response valid, one-hot or zero
- rsp_data_o  out  RW  response data, shared by all requesters, equal to rsp_data_i
- rsp_ready_i  in  N  per-requester response ready
- outstanding_o  out  CntW  current number of queue entries

## Operation
- Index queue: circular buffer of Depth entries × IdxW bits, with write pointer, read pointer and count. full = (count == Depth); empty = (count == 0).
- Request path is combinational and has zero latency:
  - req_valid_o = arb_valid_i & ~full & ~rst_i
  - arb_ready_o = req_ready_i & ~full & ~rst_i
- Push: when req_valid_o & req_ready_i, write arb_idx_i at the write pointer and advance the pointer.
- Full blocks a push even when a pop happens in the same cycle. This keeps arb_ready_o free of any combinational path from the response side.
- Response path, with head = entry at the read pointer:
  - rsp_valid_o[i] = rsp_valid_i & ~empty & (head == i)
  - rsp_ready_o = ~empty & rsp_ready_i[head]
- Pop: when rsp_valid_i & rsp_ready_o, advance the read pointer.
- Responses arriving while the queue is empty are not consumed: rsp_ready_o = 0 and rsp_valid_o = 0. An assertion flags rsp_valid_i & empty.
- Simultaneous push and pop when not full: the count is unchanged and both pointers advance.
- Pointers wrap from Depth-1 to 0. Depth need not be a power of two.
- The count saturates by construction: no push when full, no pop when empty. It is never allowed to wrap.
- outstanding_o = count.

## Timing
- Reset (rst_i high at a clock edge): count, pointers and outstanding_o go to 0. Queue contents are don't-care.
- While rst_i is high, arb_ready_o, req_valid_o, rsp_ready_o and rsp_valid_o are all 0.
- Reset asserted mid-operation discards all outstanding entries. Later responses for them are treated as unexpected (empty case).
- Request latency: 0 cycles from arb_valid_i to req_valid_o.
- Queue latency: an index pushed at edge k is visible as head from cycle k+1. The earliest possible response routing is therefore the cycle after acceptance.
- Response latency: 0 cycles from rsp_valid_i to rsp_valid_o.
- The arbiter's hold-if-not-ready rule is preserved: while arb_ready_o = 0, this block does not consume the request, so arb_idx_i and arb_data_i stay stable.
- Required assertions:
  - $onehot0(rsp_valid_o)
  - outstanding_o <= Depth
  - no push when full
  - no pop when empty

## Structure
- No shared package types are required. IdxW and CntW are local derived parameters.
- One sub-module: prim_arb_rsp_idx_fifo. It is the synchronous active-high-reset FIFO of indices, with ports for push, pop, head, full, empty and count.
- The top level contains only the handshake gating and the response demux.

## Test plan
- Reset then single transaction: N=4, Depth=4, req_ready_i=1. Arbiter presents idx 2, data 0xA5 for one cycle -> req_valid_o=1 and outstanding_o=1 next cycle. rsp_valid_i with data 0x5A -> rsp_valid_o=4'b0100, rsp_data_o=0x5A, outstanding_o=0 after the handshake.
- Fill to full: 4 back-to-back requests with idx 0,1,2,3 and no responses -> outstanding_o=4, then arb_ready_o=0 and req_valid_o=0 while arb_valid_i=1. Hold one response in the full state with push pending -> no push that cycle; arb_ready_o=1 from the next cycle.
- In-order routing with stall: queue holds 3,1. rsp_ready_i=4'b0001 -> rsp_valid_o=4'b1000 and rsp_ready_o=0 (held). Set rsp_ready_i[3]=1 -> pop; next head routes to rsp_valid_o=4'b0010.
- Simultaneous push/pop at count 2 -> count stays 2. Pointers wrap correctly across at least 2×Depth transactions with Depth=3 (non-power-of-two).
- Unexpected response while empty -> rsp_ready_o=0, rsp_valid_o=0, assertion fires in the negative test.
- Reset with 3 outstanding -> one cycle later outstanding_o=0, and all outputs are 0 while rst_i is high.
